// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines between MEM stage and memory.
// Read hits return data combinationally; misses refill a whole line, stores always go to memory then release via WDONE.
module dcache_ctrl #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cache_stall,
    output logic              cache_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [31:0]         data_arr [LINES][4];
    logic [ADDR_W-1:2]   lat_addr;
    logic [1:0]          k;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          word;
    logic                lookup_hit;
    logic [IDX_W-1:0]    l_idx;
    logic [TAG_W-1:0]    l_tag;
    logic [1:0]          l_word;
    logic                l_match;
    logic                unused_bits;

    assign idx        = cpu_addr[4 +: IDX_W];
    assign tag        = cpu_addr[ADDR_W-1 -: TAG_W];
    assign word       = cpu_addr[3:2];
    assign lookup_hit = valid[idx] && (tag_arr[idx] == tag);
    assign unused_bits = ^cpu_addr[1:0];

    assign l_idx   = lat_addr[4 +: IDX_W];
    assign l_tag   = lat_addr[ADDR_W-1 -: TAG_W];
    assign l_word  = lat_addr[3:2];
    assign l_match = valid[l_idx] && (tag_arr[l_idx] == l_tag);

    assign cpu_rdata   = data_arr[idx][word];
    assign cache_hit   = lookup_hit && (cpu_read || cpu_write);
    // Combinational so a miss or store freezes the pipeline in its very first cycle.
    assign cache_stall = ((state == IDLE) && (cpu_write || (cpu_read && !lookup_hit)))
                       || (state == REFILL) || (state == WRITE);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_addr   <= '0;
            k          <= 2'd0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_write) begin
                        if (lookup_hit) hit_count  <= sat_inc(hit_count);
                        else            miss_count <= sat_inc(miss_count);
                        lat_addr  <= cpu_addr[ADDR_W-1:2];
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                        state     <= WRITE;
                    end else if (cpu_read) begin
                        if (lookup_hit) begin
                            hit_count <= sat_inc(hit_count);
                        end else begin
                            miss_count <= sat_inc(miss_count);
                            // The victim line is invalid until all four words have landed.
                            valid[idx] <= 1'b0;
                            lat_addr   <= cpu_addr[ADDR_W-1:2];
                            k          <= 2'd0;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= {cpu_addr[ADDR_W-1:4], 4'b0000};
                            state      <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        k <= k + 2'd1;
                        if (k == 2'd3) begin
                            valid[l_idx] <= 1'b1;
                            mem_req      <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            mem_addr <= {lat_addr[ADDR_W-1:4], k + 2'd1, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= WDONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ready) begin
            data_arr[l_idx][k] <= mem_rdata;
            if (k == 2'd3) tag_arr[l_idx] <= l_tag;
        end
        if (state == WRITE && mem_ready && l_match)
            data_arr[l_idx][l_word] <= mem_wdata;
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboarded bench for dcache_ctrl: directed loads/stores against a latency-L memory model.
module tb_dcache_ctrl;
    localparam int L = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mop_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cache_stall, cache_hit;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;
    int age = 0;
    int rd_beats = 0;
    mop_t        exp_mem[$];
    logic [31:0] exp_load[$];
    mop_t        e;
    logic [31:0] ld;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(16), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cache_stall(cache_stall), .cache_hit(cache_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory: answers L cycles after a request is first seen, checks each completed op against the queue.
    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (mem_req) begin
            if (age == L) begin
                age = 0;
                mem_ready = 1'b1;
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected actual=%h expected=none", mem_addr);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.data);
                end
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                else begin
                    mem_rdata = mem[mem_addr[11:2]];
                    rd_beats++;
                end
            end else begin
                age++;
            end
        end else begin
            age = 0;
        end
    end

    // Load monitor: an accepted load is one presented in a non-stalled cycle.
    always @(negedge clk) begin
        if (!reset && cpu_read && !cpu_write && !cache_stall) begin
            if (exp_load.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load_unexpected actual=%h expected=none", cpu_rdata);
            end else begin
                ld = exp_load.pop_front();
                chk("load_data", cpu_rdata, ld);
                chk("load_hit", {31'b0, cache_hit}, 32'd1);
            end
        end
    end

    task automatic push_refill(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            exp_mem.push_back('{we: 1'b0, addr: (a & ~32'hF) + 32'(i * 4), data: 32'h0});
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input bit miss);
        int n = 0;
        @(posedge clk); #1;
        cpu_read = 1'b1;
        cpu_addr = a;
        exp_load.push_back(d);
        if (miss) push_refill(a);
        @(negedge clk);
        while (cache_stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("read_stall_cycles", 32'(n), miss ? 32'd13 : 32'd0);
        @(posedge clk); #1;
        cpu_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit with_read);
        int n = 0;
        @(posedge clk); #1;
        cpu_write = 1'b1;
        cpu_read  = with_read;
        cpu_addr  = a;
        cpu_wdata = d;
        exp_mem.push_back('{we: 1'b1, addr: a, data: d});
        @(negedge clk);
        while (cache_stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("write_stall_cycles", 32'(n), 32'd4);
        @(posedge clk); #1;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = {16'hBEEF, 16'(i * 4)};
        mem[8] = 32'hAAAA0001;
        mem_ready = 1'b0;
        mem_rdata = '0;
        reset = 1'b1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_stall", {31'b0, cache_stall}, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_read(32'd32, 32'hAAAA0001, 1'b1);
        chk("miss_after_refill", miss_count, 32'd1);
        chk("hit_after_refill", hit_count, 32'd1);

        do_read(32'd36, 32'hBEEF0024, 1'b0);
        chk("hit_reread", hit_count, 32'd2);

        do_write(32'd32, 32'h55, 1'b0);
        chk("hit_store", hit_count, 32'd3);
        chk("miss_store_hit", miss_count, 32'd1);

        do_read(32'd32, 32'h55, 1'b0);
        chk("hit_read_updated", hit_count, 32'd4);

        do_read(32'd1056, 32'hBEEF0420, 1'b1);
        chk("miss_conflict", miss_count, 32'd2);
        do_read(32'd32, 32'h55, 1'b1);
        chk("miss_refetch", miss_count, 32'd3);
        chk("hit_refetch", hit_count, 32'd6);

        // Read and write together behave as a store; store miss must not allocate.
        do_write(32'd2048, 32'h77, 1'b1);
        chk("miss_store_miss", miss_count, 32'd4);
        do_read(32'd2048, 32'h77, 1'b1);
        chk("miss_after_nwa", miss_count, 32'd5);
        chk("hit_after_nwa", hit_count, 32'd7);

        // Reset in the middle of the third refill beat.
        @(posedge clk); #1;
        b0 = rd_beats;
        cpu_read = 1'b1;
        cpu_addr = 32'd64;
        push_refill(32'd64);
        n = 0;
        while (rd_beats < b0 + 2 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("beats_before_reset", 32'(rd_beats - b0), 32'd2);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_read = 1'b0;
        #1;
        chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_stall", {31'b0, cache_stall}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        exp_mem.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_hit_count", hit_count, 32'd0);
        chk("midrst_miss_count", miss_count, 32'd0);
        do_read(32'd64, 32'hBEEF0040, 1'b1);
        chk("miss_after_rst", miss_count, 32'd1);
        chk("hit_after_rst", hit_count, 32'd1);

        repeat (4) @(posedge clk);
        chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
        chk("load_queue_drained", 32'(exp_load.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
